imem_loader: RTL

- Boot-time loader directly upstream of the instruction memory and of the CPU core's reset.
- Receives a byte stream (header plus program image) over a valid/ready handshake.
- Assembles big-endian 32-bit instruction words and writes them through the IM write port at word addresses 0..N-1.
- Holds the CPU in reset until the whole image is written, then releases it.

---
 rtl/imem_loader_pkg.sv | 24 ++
 rtl/imem_word_packer.sv | 36 +++
 rtl/imem_loader.sv | 119 +++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader:
// FSM state encodings, stream framing constants and the header check.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    LD_IDLE  = 3'd0,
    LD_HDR   = 3'd1,
    LD_LOAD  = 3'd2,
    LD_WRITE = 3'd3,
    LD_DONE  = 3'd4,
    LD_ERROR = 3'd5
  } ld_state_e;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_W          = $clog2(HDR_BYTES);
  localparam int LANE_W         = $clog2(BYTES_PER_WORD);

  // A word count is usable when it is non-zero and fits the IM (full depth allowed).
  function automatic logic hdr_count_ok(input logic [15:0] n, input int addr_w);
    return (n != 16'd0) && ({16'd0, n} <= (32'd1 << addr_w));
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Collects four stream bytes into one big-endian instruction word.
// The first byte of each group ends up in bits [31:24].
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        strobe,
  input  logic [7:0]  byte_in,
  output logic        word_ready,
  output logic [31:0] word
);

  logic [LANE_W-1:0] lane;
  logic [31:0]       shreg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lane <= '0;
    end else if (strobe) begin
      lane <= lane + LANE_W'(1);
    end
  end

  // Shifting left places earlier bytes in the more significant lanes.
  always_ff @(posedge clk) begin
    if (strobe) begin
      shreg <= {shreg[23:0], byte_in};
    end
  end

  assign word_ready = strobe && (lane == LANE_W'(BYTES_PER_WORD - 1));
  assign word       = shreg;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a 2-byte word-count header, writes the image into IM
// at word addresses 0..N-1, then releases the core from reset.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_W      = 10,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int TMO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
  localparam logic [HDR_W-1:0] HDR_LAST = HDR_W'(HDR_BYTES - 1);

  ld_state_e         state, next_state;
  logic              accept;
  logic              tmo_hit;
  logic              load_start;
  logic [HDR_W-1:0]  hdr_idx;
  logic [15:0]       n_words;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              word_ready;
  logic [31:0]       word;

  assign accept     = byte_valid && byte_ready;
  assign load_start = (state == LD_IDLE) && start;
  // Abort on the idle cycle that would bring the counter up to TIMEOUT_CYC.
  assign tmo_hit    = (TIMEOUT_CYC != 0) && !accept && (tmo_cnt == TMO_LAST);

  imem_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (load_start),
    .strobe     (accept && (state == LD_LOAD)),
    .byte_in    (byte_in),
    .word_ready (word_ready),
    .word       (word)
  );

  always_comb begin
    next_state = state;
    case (state)
      LD_IDLE:  if (start) next_state = LD_HDR;
      LD_HDR: begin
        if (accept && (hdr_idx == HDR_LAST)) begin
          next_state = hdr_count_ok({n_words[7:0], byte_in}, ADDR_W) ? LD_LOAD : LD_ERROR;
        end else if (tmo_hit) begin
          next_state = LD_ERROR;
        end
      end
      LD_LOAD: begin
        if (word_ready)   next_state = LD_WRITE;
        else if (tmo_hit) next_state = LD_ERROR;
      end
      LD_WRITE: next_state = ((32'(word_count) + 32'd1) == 32'(n_words)) ? LD_DONE : LD_LOAD;
      LD_DONE:  next_state = LD_DONE;
      LD_ERROR: next_state = LD_ERROR;
      default:  next_state = LD_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LD_IDLE;
      byte_ready <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      cpu_reset  <= 1'b1;
      word_count <= '0;
      hdr_idx    <= '0;
      tmo_cnt    <= '0;
    end else begin
      state      <= next_state;
      byte_ready <= (next_state == LD_HDR) || (next_state == LD_LOAD);
      done       <= (next_state == LD_DONE);
      error      <= (next_state == LD_ERROR);
      cpu_reset  <= (next_state != LD_DONE);
      if (load_start) begin
        word_count <= '0;
        hdr_idx    <= '0;
      end else begin
        if (state == LD_WRITE)         word_count <= word_count + CNT_W'(1);
        if ((state == LD_HDR) && accept) hdr_idx  <= hdr_idx + HDR_W'(1);
      end
      if (((state == LD_HDR) || (state == LD_LOAD)) && !accept) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if ((state == LD_HDR) && accept) begin
      n_words <= {n_words[7:0], byte_in};
    end
  end

  assign im_we    = (state == LD_WRITE);
  assign im_addr  = im_we ? word_count[ADDR_W-1:0] : '0;
  assign im_wdata = im_we ? word : '0;

endmodule
